// File: rtl/axis_byte_packer_if.sv
// -----------------------------------------------------------------------------
// axis_byte_packer_if
//
// Purpose: one AXI4-Stream channel (data, byte keep, last, valid/ready) shared
// by both sides of the byte packer.
//
// Signals:
//   tdata   DATA_BYTES*8  payload, lane i = bits [8i+7:8i]
//   tkeep   DATA_BYTES    byte-valid per lane
//   tlast   1             end of frame
//   tvalid  1             source has a beat
//   tready  1             sink accepts the beat
//
// Modports:
//   master  drives tdata/tkeep/tlast/tvalid, observes tready
//   slave   observes tdata/tkeep/tlast/tvalid, drives tready
// -----------------------------------------------------------------------------
interface axis_byte_packer_if #(
  parameter int DATA_BYTES = 4
) ();

  logic [DATA_BYTES*8-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (
    output tdata,
    output tkeep,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_byte_packer.sv
// -----------------------------------------------------------------------------
// axis_byte_packer
//
// Purpose: AXI4-Stream byte compactor. Slave beats may carry any TKEEP
// pattern; null bytes are squeezed out and the kept bytes are repacked,
// little-endian and contiguous, into full master words. On TLAST any partial
// residue is flushed as a final word with contiguous low TKEEP bits. A frame
// that ends with no pending bytes is still marked: either the full word pushed
// by the TLAST beat carries TLAST, or an empty beat (TKEEP=0, TLAST=1) is sent.
// Packed words pass through an output FIFO whose head is held in registers.
//
// Parameters:
//   DATA_BYTES  bytes per beat on both sides (2..16)
//   FIFO_DEPTH  output FIFO entries (power of two, >= 4)
//   FIFO_AW     FIFO pointer width (derived)
//
// Ports:
//   S_AXIS_ACLK     in   clock for the whole block
//   S_AXIS_ARESETN  in   asynchronous active-low reset (release synchronously)
//   s_axis          slave modport: input stream, tready is registered
//   m_axis          master modport: packed output stream, all outputs registered
//   frame_bytes     out  [15:0] kept-byte count of the last completed frame
//                        (saturating)                   -- AXIS_PACK_STATS_EN only
//   frame_done      out  one-cycle pulse after a TLAST input beat is accepted
//                                                       -- AXIS_PACK_STATS_EN only
//
// Build option: define AXIS_PACK_STATS_EN to add the frame statistics ports.
// -----------------------------------------------------------------------------
module axis_byte_packer #(
  parameter int  DATA_BYTES = 4,
  parameter int  FIFO_DEPTH = 8,
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic                S_AXIS_ACLK,
  input  logic                S_AXIS_ARESETN,
  axis_byte_packer_if.slave   s_axis,
  axis_byte_packer_if.master  m_axis
`ifdef AXIS_PACK_STATS_EN
  ,
  output logic [15:0]         frame_bytes,
  output logic                frame_done
`endif
);

  localparam int DW        = DATA_BYTES * 8;
  // Worst case holding: DATA_BYTES-1 leftover bytes plus a full new beat.
  localparam int ACC_BYTES = 2 * DATA_BYTES - 1;
  localparam int ACC_W     = ACC_BYTES * 8;
  localparam int CW        = $clog2(2 * DATA_BYTES);
  localparam int KW        = $clog2(DATA_BYTES + 1);
  // FIFO entry layout: {last, keep, data}
  localparam int EW        = DW + DATA_BYTES + 1;

  // ---------------------------------------------------------------------------
  // Accumulator state
  // ---------------------------------------------------------------------------
  // Invariant: bytes of acc_reg at and above acc_cnt_reg are always zero, so
  // any word cut from it already has zeros in its unused lanes.
  logic [ACC_W-1:0] acc_reg;
  logic [CW-1:0]    acc_cnt_reg;
  logic [ACC_W-1:0] acc_next;
  logic [CW-1:0]    acc_cnt_next;

  logic             s_ready_reg;
  logic             beat_fire;

  logic [7:0]       in_byte [DATA_BYTES];
  logic [ACC_W-1:0] merged;
  logic [ACC_W-1:0] rest;
  logic [KW-1:0]    kcnt;
  logic [CW-1:0]    sum;
  logic [CW-1:0]    residue;
  logic [DATA_BYTES-1:0] sum_mask;
  logic [DATA_BYTES-1:0] res_mask;

  // Words produced by the current beat (w0 first, then w1)
  logic [EW-1:0]    w0;
  logic [EW-1:0]    w1;
  logic [1:0]       push_cnt;

  assign beat_fire = s_axis.tvalid & s_ready_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
      assign in_byte[gi]  = s_axis.tdata[gi*8 +: 8];
      // Contiguous low-lane masks for a partial word of sum / residue bytes
      assign sum_mask[gi] = (CW'(gi) < sum);
      assign res_mask[gi] = (CW'(gi) < residue);
    end
  endgenerate

  // Drop null lanes and append the kept bytes, in ascending lane order,
  // directly after the bytes already held.
  always_comb begin
    int pos;
    pos    = 0;
    merged = acc_reg;
    kcnt   = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (s_axis.tkeep[i]) begin
        pos = int'(acc_cnt_reg) + int'(kcnt);
        if (pos < ACC_BYTES) begin
          merged[pos*8 +: 8] = in_byte[i];
        end
        kcnt = kcnt + 1'b1;
      end
    end
  end

  assign sum     = acc_cnt_reg + CW'(kcnt);
  // Only meaningful when sum >= DATA_BYTES
  assign residue = sum - CW'(DATA_BYTES);
  assign rest    = merged >> DW;

  // Word generation and next accumulator contents for the current beat.
  always_comb begin
    w0           = '0;
    w1           = '0;
    push_cnt     = 2'd0;
    acc_next     = acc_reg;
    acc_cnt_next = acc_cnt_reg;
    if (beat_fire) begin
      if (sum >= CW'(DATA_BYTES)) begin
        w0 = {1'b0, {DATA_BYTES{1'b1}}, merged[DW-1:0]};
        if (s_axis.tlast) begin
          acc_next     = '0;
          acc_cnt_next = '0;
          if (residue == '0) begin
            // Frame ends exactly on a word boundary: the full word closes it.
            w0[EW-1] = 1'b1;
            push_cnt = 2'd1;
          end else begin
            w1       = {1'b1, res_mask, rest[DW-1:0]};
            push_cnt = 2'd2;
          end
        end else begin
          push_cnt     = 2'd1;
          acc_next     = rest;
          acc_cnt_next = residue;
        end
      end else if (s_axis.tlast) begin
        // Partial (possibly empty) closing word; sum == 0 yields KEEP=0.
        w0           = {1'b1, sum_mask, merged[DW-1:0]};
        push_cnt     = 2'd1;
        acc_next     = '0;
        acc_cnt_next = '0;
      end else begin
        acc_next     = merged;
        acc_cnt_next = sum;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO with registered head
  // ---------------------------------------------------------------------------
  logic [EW-1:0]      mem_reg [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg;
  logic [FIFO_AW-1:0] rd_ptr_reg;
  logic [FIFO_AW:0]   count_reg;
  logic [FIFO_AW-1:0] wr_ptr_p1;
  logic [FIFO_AW-1:0] wr_ptr_next;
  logic [FIFO_AW-1:0] rd_ptr_next;
  logic [FIFO_AW:0]   count_next;
  logic               pop;
  logic [EW-1:0]      head_next;

  logic               m_valid_reg;
  logic [DW-1:0]      m_data_reg;
  logic [DATA_BYTES-1:0] m_keep_reg;
  logic               m_last_reg;

  assign pop         = m_valid_reg & m_axis.tready;
  assign wr_ptr_p1   = wr_ptr_reg + 1'b1;
  assign wr_ptr_next = wr_ptr_reg + FIFO_AW'(push_cnt);
  assign rd_ptr_next = rd_ptr_reg + FIFO_AW'(pop);
  assign count_next  = count_reg + (FIFO_AW+1)'(push_cnt) - (FIFO_AW+1)'(pop);

  // Next head entry. Slots being written this cycle are bypassed so a word
  // pushed at an edge is visible on the outputs right after that edge. When
  // nothing is popped the head slot is untouched, keeping outputs stable.
  always_comb begin
    head_next = '0;
    if (count_next != '0) begin
      if ((push_cnt != 2'd0) && (rd_ptr_next == wr_ptr_reg)) begin
        head_next = w0;
      end else if ((push_cnt == 2'd2) && (rd_ptr_next == wr_ptr_p1)) begin
        head_next = w1;
      end else begin
        head_next = mem_reg[rd_ptr_next];
      end
    end
  end

  // Storage array; pushes only ever target free slots.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (push_cnt != 2'd0) begin
      mem_reg[wr_ptr_reg] <= w0;
    end
    if (push_cnt == 2'd2) begin
      mem_reg[wr_ptr_p1] <= w1;
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      acc_reg     <= '0;
      acc_cnt_reg <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      s_ready_reg <= 1'b0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_keep_reg  <= '0;
      m_last_reg  <= 1'b0;
    end else begin
      acc_reg     <= acc_next;
      acc_cnt_reg <= acc_cnt_next;
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      // A beat can push two words, so demand two free slots. Using the
      // next-state occupancy keeps M_AXIS_TREADY out of any comb path here.
      s_ready_reg <= (count_next <= (FIFO_AW+1)'(FIFO_DEPTH - 2));
      m_valid_reg <= (count_next != '0);
      m_data_reg  <= head_next[DW-1:0];
      m_keep_reg  <= head_next[DW +: DATA_BYTES];
      m_last_reg  <= head_next[EW-1];
    end
  end

  assign s_axis.tready = s_ready_reg;
  assign m_axis.tvalid = m_valid_reg;
  assign m_axis.tdata  = m_data_reg;
  assign m_axis.tkeep  = m_keep_reg;
  assign m_axis.tlast  = m_last_reg;

`ifdef AXIS_PACK_STATS_EN
  // ---------------------------------------------------------------------------
  // Per-frame kept-byte statistics
  // ---------------------------------------------------------------------------
  logic [15:0] run_bytes_reg;
  logic [15:0] frame_bytes_reg;
  logic        frame_done_reg;
  logic [16:0] run_sum;
  logic [15:0] run_sat;

  assign run_sum = {1'b0, run_bytes_reg} + 17'(kcnt);
  assign run_sat = run_sum[16] ? 16'hFFFF : run_sum[15:0];

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      run_bytes_reg   <= '0;
      frame_bytes_reg <= '0;
      frame_done_reg  <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (beat_fire) begin
        if (s_axis.tlast) begin
          frame_bytes_reg <= run_sat;
          frame_done_reg  <= 1'b1;
          run_bytes_reg   <= '0;
        end else begin
          run_bytes_reg <= run_sat;
        end
      end
    end
  end

  assign frame_bytes = frame_bytes_reg;
  assign frame_done  = frame_done_reg;
`endif

endmodule

// File: tb/tb_axis_byte_packer.sv
// -----------------------------------------------------------------------------
// tb_axis_byte_packer
//
// Directed scenarios followed by a randomized stream. Expected output words
// come from a byte-queue model: kept bytes are appended to a frame byte queue,
// full words are cut from its front, and TLAST flushes the remainder.
// -----------------------------------------------------------------------------
module tb_axis_byte_packer;

  localparam int DB    = 4;
  localparam int DW    = DB * 8;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [DB-1:0] keep;
    logic          last;
  } word_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  axis_byte_packer_if #(.DATA_BYTES(DB)) s_if ();
  axis_byte_packer_if #(.DATA_BYTES(DB)) m_if ();

`ifdef AXIS_PACK_STATS_EN
  logic [15:0] frame_bytes;
  logic        frame_done;
`endif

  axis_byte_packer #(
    .DATA_BYTES(DB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .s_axis         (s_if),
    .m_axis         (m_if)
`ifdef AXIS_PACK_STATS_EN
    ,
    .frame_bytes    (frame_bytes),
    .frame_done     (frame_done)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

  byte unsigned pend[$];
  word_t        expq[$];
  int           frame_cnt = 0;
  int           exp_fb = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_if.tready = 1'b0;
      1:       m_if.tready = 1'b1;
      default: m_if.tready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  // Reference model of one accepted input beat.
  task automatic model_beat(input logic [DW-1:0] d, input logic [DB-1:0] k, input logic l);
    word_t w;
    bit    emitted;
    int    n;
    emitted = 0;
    for (int i = 0; i < DB; i++) begin
      if (k[i]) pend.push_back(d[i*8 +: 8]);
    end
    frame_cnt += $countones(k);
    if (pend.size() >= DB) begin
      w = '0;
      for (int i = 0; i < DB; i++) w.data[i*8 +: 8] = pend.pop_front();
      w.keep = '1;
      expq.push_back(w);
      emitted = 1;
    end
    if (l) begin
      if (pend.size() > 0) begin
        w = '0;
        n = pend.size();
        for (int i = 0; i < n; i++) begin
          w.data[i*8 +: 8] = pend.pop_front();
          w.keep[i] = 1'b1;
        end
        w.last = 1'b1;
        expq.push_back(w);
      end else if (emitted) begin
        w = expq.pop_back();
        w.last = 1'b1;
        expq.push_back(w);
      end else begin
        w = '0;
        w.last = 1'b1;
        expq.push_back(w);
      end
      exp_fb = (frame_cnt > 65535) ? 65535 : frame_cnt;
      frame_cnt = 0;
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [DB-1:0] k, input logic l,
                           input int budget, output bit ok);
    bit acc;
    ok = 0;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      acc = s_if.tready;
      tick();
      if (acc) begin
        ok = 1;
        model_beat(d, k, l);
`ifdef AXIS_PACK_STATS_EN
        if (l) begin
          chk("frame_done_pulse", 64'(frame_done), 64'd1);
          chk("frame_bytes", 64'(frame_bytes), 64'(exp_fb));
        end
`endif
      end
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_ok(input string tag, input logic [DW-1:0] d, input logic [DB-1:0] k,
                         input logic l);
    bit ok;
    send_beat(d, k, l, 32, ok);
    chk(tag, 64'(ok), 64'd1);
  endtask

  task automatic drain(input string tag);
    ready_mode = 1;
    for (int c = 0; c < 400 && expq.size() != 0; c++) tick();
    chk(tag, 64'(expq.size()), 64'd0);
    tick();
    chk({tag, "_idle_valid"}, 64'(m_if.tvalid), 64'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    s_if.tvalid = 1'b0;
    pend.delete();
    expq.delete();
    frame_cnt = 0;
    #1;
    chk("rst_m_valid", 64'(m_if.tvalid), 64'd0);
    chk("rst_m_data",  64'(m_if.tdata),  64'd0);
    chk("rst_m_keep",  64'(m_if.tkeep),  64'd0);
    chk("rst_m_last",  64'(m_if.tlast),  64'd0);
    chk("rst_s_ready", 64'(s_if.tready), 64'd0);
`ifdef AXIS_PACK_STATS_EN
    chk("rst_frame_bytes", 64'(frame_bytes), 64'd0);
    chk("rst_frame_done",  64'(frame_done),  64'd0);
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("s_ready_after_release", 64'(s_if.tready), 64'd1);
  endtask

  task automatic scenario1();
    send_ok("s1_b0", 32'h04030201, 4'hF, 1'b0);
    send_ok("s1_b1", 32'h08070605, 4'hF, 1'b0);
    send_ok("s1_b2", 32'h0C0B0A09, 4'hF, 1'b0);
    send_ok("s1_b3", 32'h100F0E0D, 4'hF, 1'b1);
    drain("s1_drain");
  endtask

  // Output monitor: scoreboard on every output transfer, and a stability check
  // for a word that was stalled at the previous sample.
  word_t         mw;
  logic [DW-1:0] hold_data;
  logic [DB-1:0] hold_keep;
  logic          hold_last;
  bit            hold = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", 64'(m_if.tvalid), 64'd1);
        chk("hold_data",  64'(m_if.tdata),  64'(hold_data));
        chk("hold_keep",  64'(m_if.tkeep),  64'(hold_keep));
        chk("hold_last",  64'(m_if.tlast),  64'(hold_last));
      end
      if (m_if.tvalid && m_if.tready) begin
        chk("out_expected", 64'(expq.size() != 0), 64'd1);
        if (expq.size() != 0) begin
          mw = expq.pop_front();
          chk("out_data", 64'(m_if.tdata), 64'(mw.data));
          chk("out_keep", 64'(m_if.tkeep), 64'(mw.keep));
          chk("out_last", 64'(m_if.tlast), 64'(mw.last));
        end
      end
      hold      = m_if.tvalid && !m_if.tready;
      hold_data = m_if.tdata;
      hold_keep = m_if.tkeep;
      hold_last = m_if.tlast;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            ok;
    int            acc_n;
    logic [7:0]    b;
    logic [DW-1:0] d;
    logic [DB-1:0] k;
    logic          l;

    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    #2;
    apply_reset();

    // Full beats pass straight through
    ready_mode = 1;
    scenario1();

    // Sparse keep=7 beats repack across word boundaries
    send_ok("s2_b0", 32'h00332211, 4'h7, 1'b0);
    send_ok("s2_b1", 32'h00332211, 4'h7, 1'b0);
    send_ok("s2_b2", 32'h00332211, 4'h7, 1'b1);
    drain("s2_drain");

    // Non-contiguous keep with garbage in dropped lanes
    send_ok("s3_b0", 32'hDDCCBBAA, 4'b1010, 1'b1);
    drain("s3_drain");

    // Empty closing beat
    send_ok("s5_b0", 32'hDEADBEEF, 4'h0, 1'b1);
`ifdef AXIS_PACK_STATS_EN
    tick();
    chk("frame_done_single_cycle", 64'(frame_done), 64'd0);
`endif
    drain("s5_drain");

    // Back-pressure: each full beat pushes one word and two free slots are
    // required to accept, so DEPTH-1 beats get in before input stalls.
    ready_mode = 0;
    tick();
    acc_n = 0;
    b = 8'h40;
    for (int i = 0; i < 20; i++) begin
      send_beat({b + 8'd3, b + 8'd2, b + 8'd1, b}, 4'hF, 1'b0, 1, ok);
      if (ok) begin
        acc_n++;
        b = b + 8'd4;
      end
    end
    chk("stall_accepts", 64'(acc_n), 64'(DEPTH - 1));
    chk("stall_s_ready", 64'(s_if.tready), 64'd0);
    chk("stall_m_valid", 64'(m_if.tvalid), 64'd1);
    drain("s4_drain");
    send_ok("s4_close", 32'h0, 4'h0, 1'b1);
    drain("s4_close_drain");

    // Reset in the middle of a frame with words still queued
    ready_mode = 0;
    tick();
    send_ok("s6_f0", 32'hA3A2A1A0, 4'hF, 1'b0);
    send_ok("s6_f1", 32'hB3B2B1B0, 4'hF, 1'b0);
    send_ok("s6_p0", 32'h00332211, 4'h7, 1'b0);
    send_ok("s6_p1", 32'h00665544, 4'h7, 1'b0);
    chk("s6_m_valid", 64'(m_if.tvalid), 64'd1);
    ready_mode = 1;
    tick();
    apply_reset();
    ready_mode = 1;
    scenario1();

    // Randomized stream under random back-pressure
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      d = $urandom;
      k = DB'($urandom_range(0, (1 << DB) - 1));
      l = ($urandom_range(0, 4) == 0);
      send_beat(d, k, l, 64, ok);
      chk("rand_accept", 64'(ok), 64'd1);
      if ($urandom_range(0, 3) == 0) tick();
    end
    send_ok("rand_close", 32'h0, 4'h0, 1'b1);
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_byte_packer.md
Name: axis_byte_packer

Overview:
Parametrised AXI4-Stream byte compactor and successor to the single-width S_AXIS-to-FIFO packer. Accepts slave beats with arbitrary (sparse) TKEEP and removes null bytes. Emits contiguous, fully packed master words through an internal output FIFO. Flushes a partial final word with correct TKEEP on TLAST. Sits between a DMA/stream source and downstream byte-oriented consumers.

Parameters:
DATA_BYTES, 4, bytes per beat on both sides; TDATA width = DATA_BYTES*8, range 2..16
FIFO_DEPTH, 8, output FIFO entries; power of 2, >=4
FIFO_AW, $clog2(FIFO_DEPTH), FIFO pointer width (derived, not overridden)

Ports:
S_AXIS_ACLK  in  1  single clock for the whole block
S_AXIS_ARESETN  in  1  asynchronous, active-low reset
S_AXIS_TDATA  in  DATA_BYTES*8  input data, lane i = bits [8i+7:8i]
S_AXIS_TKEEP  in  DATA_BYTES  byte-valid per lane; any pattern legal
S_AXIS_TLAST  in  1  end of frame
S_AXIS_TVALID  in  1  input valid
S_AXIS_TREADY  out  1  input ready (registered)
M_AXIS_TDATA  out  DATA_BYTES*8  packed output data
M_AXIS_TKEEP  out  DATA_BYTES  all-ones except on a partial last beat (contiguous low ones)
M_AXIS_TLAST  out  1  end of frame
M_AXIS_TVALID  out  1  output valid
M_AXIS_TREADY  in  1  output ready

Behaviour:
- Reset (async assert, sync release): S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TKEEP=0, M_AXIS_TLAST=0, accumulator count=0, FIFO empty. S_AXIS_TREADY rises on the first edge after release.
- Input transfer: TVALID&TREADY at a rising edge.
- Output transfer: M_AXIS_TVALID&M_AXIS_TREADY at a rising edge.
- Compaction: kept bytes are taken in ascending lane order. They are appended after the acc_cnt bytes already held, in an accumulator of 2*DATA_BYTES-1 bytes. Byte order is little-endian: first byte lands in lane 0.
- Per accepted beat with k kept bytes, sum = acc_cnt+k:
  - sum>=DATA_BYTES: push the low DATA_BYTES bytes as one word (KEEP all-ones); shift the remainder down; acc_cnt=sum-DATA_BYTES.
  - TLAST and residue>0: additionally push the residue word (KEEP low residue bits, TLAST=1, unused lanes zero); acc_cnt=0.
  - TLAST and residue==0 with a full word pushed this beat: that full word carries TLAST.
  - TLAST and sum==0: push one beat with TDATA=0, TKEEP=0, TLAST=1, so frame boundaries are never lost.
- Each beat pushes at most 2 words.
- S_AXIS_TREADY = registered (free_slots>=2), computed from next-state occupancy. No overflow is possible. No combinational path from M_AXIS_TREADY to S_AXIS_TREADY.
- Latency: a word pushed at edge n shows M_AXIS_TVALID=1 after edge n (first-word fall-through from registered head).
- Simultaneous push and pop in one cycle are both honoured; occupancy changes by pushes minus pops.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are tracked by a FIFO_AW+1 count.
- M_AXIS outputs hold stable while TVALID=1 and TREADY=0.
- Reset mid-frame discards the accumulator and all FIFO contents; no partial beat is emitted afterwards.
- TDATA on non-kept input lanes is ignored. Output lanes beyond TKEEP are always zero.

Optional Feature:
AXIS_PACK_STATS_EN
- Defined: adds output frame_bytes [15:0] and output frame_done [0:0].
  - On the cycle after the input beat carrying TLAST is accepted, frame_done pulses high for 1 cycle.
  - frame_bytes holds that frame's total kept-byte count (saturating at 16'hFFFF) until the next frame_done.
  - Both outputs reset to 0.
- Undefined: the ports and counter logic are absent. Core behaviour is identical.

Test Plan:
1. DATA_BYTES=4, four beats keep=F, data 0x04030201/0x08070605/0x0C0B0A09/0x100F0E0D, TLAST on beat 4 -> four identical output words, KEEP=F, TLAST only on the 4th.
2. Three beats data 0x00332211 keep=7, TLAST on beat 3 -> 0x11332211 KEEP F; 0x22113322 KEEP F; 0x00000033 KEEP 1 TLAST.
3. Single beat 0xDDCCBBAA keep=4'b1010 TLAST -> one beat 0x0000DDBB, KEEP 3, TLAST.
4. FIFO_DEPTH=8, M_AXIS_TREADY=0 for 20 cycles while streaming keep=F -> S_AXIS_TREADY drops once free<2. Releasing TREADY drains all words in order, none lost or duplicated.
5. Beat keep=0 TLAST with empty accumulator -> one beat TDATA=0, KEEP=0, TLAST=1. With AXIS_PACK_STATS_EN: frame_done pulse, frame_bytes=0.
6. Reset asserted after two keep=7 beats (acc_cnt=2) and mid-drain -> all outputs 0 immediately. The following frame from scenario 1 reproduces scenario 1 output exactly.
